seg7_timer_display: RTL and testbench



---
 rtl/seg7_timer_display_pkg.sv | 34 +++
 rtl/seg7_timer_display_if.sv | 13 +
 rtl/seg7_timer_display_bcd_to_seg7.sv | 27 ++
 rtl/seg7_timer_display.sv | 133 +++++++++++++
 tb/tb_seg7_timer_display.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/seg7_timer_display_pkg.sv
// Shared constants for the coin-timer 7-segment display: scan states,
// digit-enable codes and the active-low segment table.
package seg7_pkg;

    localparam logic [1:0] ST_ONES = 2'd0;
    localparam logic [1:0] ST_TENS = 2'd1;
    localparam logic [1:0] ST_MIN  = 2'd2;

    localparam logic [2:0] SEL_ONES = 3'b110;
    localparam logic [2:0] SEL_TENS = 3'b101;
    localparam logic [2:0] SEL_MIN  = 3'b011;
    localparam logic [2:0] SEL_NONE = 3'b111;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Segment order {g,f,e,d,c,b,a}, active-low, for BCD 0..9
    localparam logic [6:0] SEG_TABLE [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    function automatic logic [2:0] sel_for_state(input logic [1:0] st);
        logic [2:0] sel;
        case (st)
            ST_ONES: sel = SEL_ONES;
            ST_TENS: sel = SEL_TENS;
            ST_MIN:  sel = SEL_MIN;
            default: sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/seg7_timer_display_if.sv
// Bundle between the countdown counter (master) and the display reader (slave).
interface seg7_timer_display_if;
    logic [3:0] S1;
    logic [3:0] S2;
    logic [3:0] S3;
    logic       TimerRun;
    logic [6:0] Seg;
    logic       Dp;
    logic [2:0] DigitSel;

    modport master (output S1, S2, S3, TimerRun, input Seg, Dp, DigitSel);
    modport slave  (input S1, S2, S3, TimerRun, output Seg, Dp, DigitSel);
endinterface

// File: rtl/seg7_timer_display_bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder; non-BCD codes show a dash.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    // Table lookup with a dash for 10..15
    always_comb begin
        seg_o = SEG_DASH;
        case (bcd_i)
            4'd0:    seg_o = SEG_TABLE[0];
            4'd1:    seg_o = SEG_TABLE[1];
            4'd2:    seg_o = SEG_TABLE[2];
            4'd3:    seg_o = SEG_TABLE[3];
            4'd4:    seg_o = SEG_TABLE[4];
            4'd5:    seg_o = SEG_TABLE[5];
            4'd6:    seg_o = SEG_TABLE[6];
            4'd7:    seg_o = SEG_TABLE[7];
            4'd8:    seg_o = SEG_TABLE[8];
            4'd9:    seg_o = SEG_TABLE[9];
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_timer_display.sv
// Snapshots the countdown digits once per frame and multiplexes them onto a
// 3-digit common-anode display with colon blink and expired-flash.
module seg7_timer_display
    import seg7_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned BLINK_DIV   = 25000000,
    parameter bit          LZ_BLANK    = 1'b1
) (
    input  logic                 Clk,
    input  logic                 nReset,
    seg7_timer_display_if.slave  bus
);

    localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

    logic [PW-1:0] presc_q, presc_d;
    logic [BW-1:0] blink_q, blink_d;
    logic [1:0]    state_q, state_d;
    logic [11:0]   snap_q, snap_d;
    logic          phase_q, phase_d;
    logic          run_q;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [2:0]    sel_q, sel_d;

    logic          tick_s;
    logic          rise_s;
    logic [3:0]    digit_s;
    logic [6:0]    seg_dec_s;

    assign tick_s = (presc_q == PW'(REFRESH_DIV - 1));
    assign rise_s = bus.TimerRun & ~run_q;

    // Prescaler, scan FSM, frame snapshot and blink timing
    always_comb begin
        presc_d = tick_s ? '0 : presc_q + PW'(1);
        state_d = state_q;
        snap_d  = snap_q;
        case (state_q)
            ST_ONES: state_d = tick_s ? ST_TENS : ST_ONES;
            ST_TENS: state_d = tick_s ? ST_MIN  : ST_TENS;
            ST_MIN:  state_d = tick_s ? ST_ONES : ST_MIN;
            default: state_d = ST_ONES;
        endcase
        if (tick_s && state_q == ST_MIN) begin
            snap_d = {bus.S3, bus.S2, bus.S1};
        end else begin
            snap_d = snap_q;
        end
        // A fresh coin restarts the colon phase, overriding any wrap this cycle
        if (rise_s) begin
            blink_d = '0;
            phase_d = 1'b1;
        end else if (blink_q == BW'(BLINK_DIV - 1)) begin
            blink_d = '0;
            phase_d = ~phase_q;
        end else begin
            blink_d = blink_q + BW'(1);
            phase_d = phase_q;
        end
    end

    // Digit selected by the current scan slot
    always_comb begin
        case (state_q)
            ST_ONES: digit_s = snap_q[3:0];
            ST_TENS: digit_s = snap_q[7:4];
            ST_MIN:  digit_s = snap_q[11:8];
            default: digit_s = 4'd0;
        endcase
    end

    bcd_to_seg7 u_dec (
        .bcd_i (digit_s),
        .seg_o (seg_dec_s)
    );

    // Display mode: RUN blinks the colon, EXPIRED flashes all, HOLD is steady
    always_comb begin
        seg_d = seg_dec_s;
        dp_d  = 1'b1;
        sel_d = sel_for_state(state_q);
        if (bus.TimerRun) begin
            if (state_q == ST_MIN) begin
                dp_d = ~phase_q;
                if (LZ_BLANK && snap_q[11:8] == 4'd0) begin
                    seg_d = SEG_BLANK;
                end else begin
                    seg_d = seg_dec_s;
                end
            end else begin
                dp_d = 1'b1;
            end
        end else if (snap_q == 12'h000 && !phase_q) begin
            sel_d = SEL_NONE;
            seg_d = SEG_BLANK;
        end else begin
            seg_d = seg_dec_s;
        end
    end

    // State and registered outputs
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            presc_q <= '0;
            blink_q <= '0;
            state_q <= ST_ONES;
            snap_q  <= 12'h000;
            phase_q <= 1'b1;
            run_q   <= 1'b0;
            seg_q   <= SEG_BLANK;
            dp_q    <= 1'b1;
            sel_q   <= SEL_NONE;
        end else begin
            presc_q <= presc_d;
            blink_q <= blink_d;
            state_q <= state_d;
            snap_q  <= snap_d;
            phase_q <= phase_d;
            run_q   <= bus.TimerRun;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            sel_q   <= sel_d;
        end
    end

    assign bus.Seg      = seg_q;
    assign bus.Dp       = dp_q;
    assign bus.DigitSel = sel_q;

endmodule

// File: tb/tb_seg7_timer_display.sv
// Self-checking bench: frame/blink reference model driven by edge counts,
// decoder vector table, directed scenarios and randomized traffic.
module tb_seg7_timer_display;

    localparam int R = 4;
    localparam int B = 16;

    typedef struct {
        logic [3:0] bcd;
        logic [6:0] seg;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    seg7_timer_display_if bus ();

    seg7_timer_display #(.REFRESH_DIV(R), .BLINK_DIV(B), .LZ_BLANK(1'b1)) dut (
        .Clk    (clk),
        .nReset (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: edges since release, edge index of last blink restart, snapshot
    int          m_n = 0;
    int          m_a = 0;
    logic        m_prev = 1'b0;
    logic [11:0] m_snap = 12'h000;
    logic [6:0]  exp_seg = 7'h7F;
    logic        exp_dp = 1'b1;
    logic [2:0]  exp_sel = 3'b111;

    function automatic logic [6:0] ref_dec(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0: s = 7'b1000000;  4'd1: s = 7'b1111001;
            4'd2: s = 7'b0100100;  4'd3: s = 7'b0110000;
            4'd4: s = 7'b0011001;  4'd5: s = 7'b0010010;
            4'd6: s = 7'b0000010;  4'd7: s = 7'b1111000;
            4'd8: s = 7'b0000000;  4'd9: s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    task automatic check(input string name, input logic [6:0] s, input logic d, input logic [2:0] sel);
        tests++;
        if (bus.Seg !== s || bus.Dp !== d || bus.DigitSel !== sel) begin
            fails++;
            $display("FAIL %s t=%0t: got seg=%b dp=%b sel=%b, expected seg=%b dp=%b sel=%b",
                     name, $time, bus.Seg, bus.Dp, bus.DigitSel, s, d, sel);
        end
    endtask

    task automatic model_edge(input logic run, input logic [3:0] s3, input logic [3:0] s2, input logic [3:0] s1);
        int         slot;
        logic       ph;
        logic [3:0] dig;
        slot = (m_n / R) % 3;
        ph   = (((m_n - m_a) / B) % 2) == 0;
        dig  = (slot == 0) ? m_snap[3:0] : (slot == 1) ? m_snap[7:4] : m_snap[11:8];
        exp_sel = (slot == 0) ? 3'b110 : (slot == 1) ? 3'b101 : 3'b011;
        exp_seg = ref_dec(dig);
        exp_dp  = 1'b1;
        if (run) begin
            if (slot == 2) begin
                exp_dp = ~ph;
                if (m_snap[11:8] == 4'd0) exp_seg = 7'b1111111;
            end
        end else if (m_snap == 12'h000 && !ph) begin
            exp_sel = 3'b111;
            exp_seg = 7'b1111111;
        end
        if (run && !m_prev) m_a = m_n + 1;
        m_n++;
        if (m_n % (3 * R) == 0) m_snap = {s3, s2, s1};
        m_prev = run;
    endtask

    task automatic step(input string name, input logic run, input logic [3:0] s3, input logic [3:0] s2, input logic [3:0] s1);
        bus.TimerRun = run;
        bus.S3 = s3;
        bus.S2 = s2;
        bus.S1 = s1;
        @(posedge clk);
        model_edge(run, s3, s2, s1);
        @(negedge clk);
        check(name, exp_seg, exp_dp, exp_sel);
        tests++;
        if ($countones(~bus.DigitSel) > 1) begin
            fails++;
            $display("FAIL onehot t=%0t: got sel=%b, expected at most one low bit", $time, bus.DigitSel);
        end
    endtask

    task automatic reset_pulse(input int cycles);
        rst_n = 1'b0;
        #1;
        check("reset_async", 7'b1111111, 1'b1, 3'b111);
        repeat (cycles) @(negedge clk);
        check("reset_hold", 7'b1111111, 1'b1, 3'b111);
        rst_n = 1'b1;
        m_n = 0;
        m_a = 0;
        m_prev = 1'b0;
        m_snap = 12'h000;
    endtask

    vec_t tbl [16];

    initial begin
        logic [3:0] r1, r2, r3;
        logic       rr;
        int         guard;

        tbl[0]  = '{4'd0,  7'b1000000}; tbl[1]  = '{4'd1,  7'b1111001};
        tbl[2]  = '{4'd2,  7'b0100100}; tbl[3]  = '{4'd3,  7'b0110000};
        tbl[4]  = '{4'd4,  7'b0011001}; tbl[5]  = '{4'd5,  7'b0010010};
        tbl[6]  = '{4'd6,  7'b0000010}; tbl[7]  = '{4'd7,  7'b1111000};
        tbl[8]  = '{4'd8,  7'b0000000}; tbl[9]  = '{4'd9,  7'b0010000};
        tbl[10] = '{4'd10, 7'b0111111}; tbl[11] = '{4'd11, 7'b0111111};
        tbl[12] = '{4'd12, 7'b0111111}; tbl[13] = '{4'd13, 7'b0111111};
        tbl[14] = '{4'd14, 7'b0111111}; tbl[15] = '{4'd15, 7'b0111111};

        bus.TimerRun = 1'b0;
        bus.S1 = 4'd0;
        bus.S2 = 4'd0;
        bus.S3 = 4'd0;
        @(negedge clk);

        // 1: reset, then EXPIRED flash at zero
        reset_pulse(5);
        for (int i = 0; i < 32; i++) begin
            step("expired", 1'b0, 4'd0, 4'd0, 4'd0);
            if (i == 0) check("expired_first_ones", 7'b1000000, 1'b1, 3'b110);
            if (i == 16) check("expired_dark", 7'b1111111, 1'b1, 3'b111);
        end

        // 2/3: run at 1:59, then change ones digit mid-frame
        for (int i = 0; i < 3 * R * 4; i++) step("run_159", 1'b1, 4'd1, 4'd5, 4'd9);
        guard = 0;
        while (((m_n / R) % 3) != 1 && guard < 3 * R) begin
            step("run_159_align", 1'b1, 4'd1, 4'd5, 4'd9);
            guard++;
        end
        for (int i = 0; i < 3 * R * 2; i++) step("run_158", 1'b1, 4'd1, 4'd5, 4'd8);

        // 4: leading-zero blanking
        for (int i = 0; i < 3 * R * 4; i++) step("run_042", 1'b1, 4'd0, 4'd4, 4'd2);

        // 5: HOLD with a non-BCD ones digit
        for (int i = 0; i < 3 * R * 4; i++) step("hold_03c", 1'b0, 4'd0, 4'd3, 4'hC);

        // 6: reset mid-TENS
        guard = 0;
        while (((m_n / R) % 3) != 1 && guard < 3 * R) begin
            step("pre_reset", 1'b0, 4'd0, 4'd3, 4'hC);
            guard++;
        end
        step("pre_reset_tens", 1'b0, 4'd0, 4'd3, 4'hC);
        reset_pulse(1);
        step("post_reset", 1'b0, 4'd0, 4'd3, 4'hC);
        check("post_reset_ones", 7'b1000000, 1'b1, 3'b110);

        // Decoder table in HOLD mode, sampled in the ONES slot
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < 3 * R * 2; k++) step("tbl_fill", 1'b0, 4'd0, 4'd3, tbl[i].bcd);
            guard = 0;
            while (exp_sel != 3'b110 && guard < 3 * R) begin
                step("tbl_align", 1'b0, 4'd0, 4'd3, tbl[i].bcd);
                guard++;
            end
            tests++;
            if (bus.Seg !== tbl[i].seg) begin
                fails++;
                $display("FAIL decode[%0d]: got seg=%b, expected %b", i, bus.Seg, tbl[i].seg);
            end
        end

        // Randomized traffic against the model
        rr = 1'b0; r1 = 4'd0; r2 = 4'd0; r3 = 4'd0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) rr = ~rr;
            if ($urandom_range(0, 9) == 0) begin
                if ($urandom_range(0, 5) == 0) begin
                    r1 = 4'd0; r2 = 4'd0; r3 = 4'd0;
                end else begin
                    r1 = 4'($urandom_range(0, 15));
                    r2 = 4'($urandom_range(0, 15));
                    r3 = 4'($urandom_range(0, 2));
                end
            end
            step("random", rr, r3, r2, r1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
